scalar_issue_ctrl: RTL and testbench

Issue and writeback scheduler for the scalar functional units: scalar logical, scalar shift and scalar integer add. It accepts one decoded scalar instruction per cycle and checks S-register reservations and shared result-bus slot availability. Accepted instructions get a one-cycle unit `go` strobe. Writeback valid, unit select and destination are produced exactly when the selected unit's result is stable. It sits between the instruction issue stage and the scalar units / S register file write port.

---
 rtl/scalar_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_scalar_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_issue_ctrl.sv
// Issue/writeback scheduler for the scalar logical, shift and add units.
// Checks S-register reservations and result-bus slots, issues unit go strobes, and times the S writeback.
module scalar_issue_ctrl #(
    parameter int LAT_LOG = 1,
    parameter int LAT_SH  = 2,
    parameter int LAT_DSH = 3,
    parameter int LAT_ADD = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_issue_vld,
    input  logic [6:0] i_instr,
    input  logic [2:0] i_i,
    input  logic [2:0] i_j,
    input  logic [2:0] i_k,
    output logic       o_issue_ack,
    output logic       o_log_go,
    output logic       o_sh_go,
    output logic       o_add_go,
    output logic       o_wb_vld,
    output logic [1:0] o_wb_sel,
    output logic [2:0] o_wb_addr,
    output logic [7:0] o_s_busy,
    output logic       o_bad_op
);

    localparam logic [1:0] SEL_LOG = 2'd0;
    localparam logic [1:0] SEL_SH  = 2'd1;
    localparam logic [1:0] SEL_ADD = 2'd2;

    // Writeback pipeline; entry 0 drives the writeback outputs.
    logic [2:0] p_v;
    logic [1:0] p_sel  [3];
    logic [2:0] p_addr [3];
    logic [2:0] nxt_v;
    logic [1:0] nxt_sel  [3];
    logic [2:0] nxt_addr [3];

    logic [7:0] s_busy;
    logic [7:0] busy_set;
    logic [7:0] busy_clr;
    logic       bad_op;

    logic       is_log;
    logic       is_log_const;
    logic       is_sh;
    logic       is_dsh;
    logic       is_add;
    logic       is_known;
    logic       chk_i;
    logic       chk_j;
    logic       chk_k;
    logic       src_busy;
    logic       slot_busy;
    logic       accept;
    logic       accept_known;
    logic [1:0] lat;
    logic [1:0] cls_sel;

    // Opcode classification
    always_comb begin
        is_log       = (i_instr >= 7'o042) && (i_instr <= 7'o051);
        is_log_const = (i_instr == 7'o042) || (i_instr == 7'o043);
        is_sh        = (i_instr >= 7'o052) && (i_instr <= 7'o055);
        is_dsh       = (i_instr == 7'o056) || (i_instr == 7'o057);
        is_add       = (i_instr == 7'o060) || (i_instr == 7'o061);
        is_known     = is_log | is_sh | is_dsh | is_add;
    end

    always_comb begin
        lat     = 2'd3;
        cls_sel = SEL_LOG;
        if (is_log) begin
            lat     = 2'(LAT_LOG);
            cls_sel = SEL_LOG;
        end else if (is_sh) begin
            lat     = 2'(LAT_SH);
            cls_sel = SEL_SH;
        end else if (is_dsh) begin
            lat     = 2'(LAT_DSH);
            cls_sel = SEL_SH;
        end else if (is_add) begin
            lat     = 2'(LAT_ADD);
            cls_sel = SEL_ADD;
        end
    end

    // A zero j/k field selects a constant, never a register.
    always_comb begin
        chk_i = 1'b0;
        chk_j = 1'b0;
        chk_k = 1'b0;
        if (is_log && !is_log_const) begin
            chk_j = (i_j != 3'd0);
            chk_k = (i_k != 3'd0);
        end else if (is_sh) begin
            chk_i = 1'b1;
        end else if (is_dsh) begin
            chk_i = 1'b1;
            chk_j = (i_j != 3'd0);
        end else if (is_add) begin
            chk_j = (i_j != 3'd0);
            chk_k = (i_k != 3'd0);
        end
    end

    always_comb begin
        src_busy = (chk_i & s_busy[i_i]) | (chk_j & s_busy[i_j]) | (chk_k & s_busy[i_k]);
        case (lat)
            2'd1:    slot_busy = p_v[1];
            2'd2:    slot_busy = p_v[2];
            default: slot_busy = 1'b0;
        endcase
    end

    always_comb begin
        o_issue_ack  = is_known ? (!src_busy && !s_busy[i_i] && !slot_busy) : 1'b1;
        accept       = i_issue_vld & o_issue_ack;
        accept_known = accept & is_known;
        o_log_go     = accept & is_log;
        o_sh_go      = accept & (is_sh | is_dsh);
        o_add_go     = accept & is_add;
    end

    // Shift toward the output; the new result lands L-1 slots from the front.
    always_comb begin
        nxt_v       = {1'b0, p_v[2], p_v[1]};
        nxt_sel[0]  = p_sel[1];
        nxt_sel[1]  = p_sel[2];
        nxt_sel[2]  = 2'd0;
        nxt_addr[0] = p_addr[1];
        nxt_addr[1] = p_addr[2];
        nxt_addr[2] = 3'd0;
        if (accept_known) begin
            case (lat)
                2'd1: begin
                    nxt_v[0]    = 1'b1;
                    nxt_sel[0]  = cls_sel;
                    nxt_addr[0] = i_i;
                end
                2'd2: begin
                    nxt_v[1]    = 1'b1;
                    nxt_sel[1]  = cls_sel;
                    nxt_addr[1] = i_i;
                end
                default: begin
                    nxt_v[2]    = 1'b1;
                    nxt_sel[2]  = cls_sel;
                    nxt_addr[2] = i_i;
                end
            endcase
        end
    end

    always_comb begin
        busy_clr = p_v[0] ? (8'd1 << p_addr[0]) : 8'd0;
        busy_set = accept_known ? (8'd1 << i_i) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_v    <= 3'd0;
            s_busy <= 8'd0;
            bad_op <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                p_sel[n]  <= 2'd0;
                p_addr[n] <= 3'd0;
            end
        end else begin
            p_v    <= nxt_v;
            s_busy <= (s_busy & ~busy_clr) | busy_set;
            bad_op <= accept & ~is_known;
            for (int n = 0; n < 3; n++) begin
                p_sel[n]  <= nxt_sel[n];
                p_addr[n] <= nxt_addr[n];
            end
        end
    end

    assign o_wb_vld  = p_v[0];
    assign o_wb_sel  = p_sel[0];
    assign o_wb_addr = p_addr[0];
    assign o_s_busy  = s_busy;
    assign o_bad_op  = bad_op;

endmodule

// File: tb/tb_scalar_issue_ctrl.sv
// Randomized scoreboard bench for scalar_issue_ctrl against a cycle-indexed reference model.
module tb_scalar_issue_ctrl;

    localparam int LAT_LOG = 1;
    localparam int LAT_SH  = 2;
    localparam int LAT_DSH = 3;
    localparam int LAT_ADD = 3;

    logic       clk;
    logic       rst_n;
    logic       i_issue_vld;
    logic [6:0] i_instr;
    logic [2:0] i_i, i_j, i_k;
    logic       o_issue_ack, o_log_go, o_sh_go, o_add_go;
    logic       o_wb_vld;
    logic [1:0] o_wb_sel;
    logic [2:0] o_wb_addr;
    logic [7:0] o_s_busy;
    logic       o_bad_op;

    scalar_issue_ctrl #(
        .LAT_LOG(LAT_LOG), .LAT_SH(LAT_SH), .LAT_DSH(LAT_DSH), .LAT_ADD(LAT_ADD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_issue_vld(i_issue_vld), .i_instr(i_instr),
        .i_i(i_i), .i_j(i_j), .i_k(i_k), .o_issue_ack(o_issue_ack),
        .o_log_go(o_log_go), .o_sh_go(o_sh_go), .o_add_go(o_add_go),
        .o_wb_vld(o_wb_vld), .o_wb_sel(o_wb_sel), .o_wb_addr(o_wb_addr),
        .o_s_busy(o_s_busy), .o_bad_op(o_bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit ack, lgo, sgo, ago, wbv, bad;
        int wbsel, wbaddr, busy;
    } rec_t;
    rec_t exp_q[$];

    // Reference model: busy flags plus a ring of writebacks indexed by cycle number.
    bit m_busy [8];
    bit sch_v [8];
    int sch_sel [8];
    int sch_addr [8];
    bit m_bad;
    int cyc;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 8; b++) begin
            m_busy[b]   = 0;
            sch_v[b]    = 0;
            sch_sel[b]  = 0;
            sch_addr[b] = 0;
        end
        m_bad = 0;
    endfunction

    // cls: 0 logical, 1 shift, 2 add; known=0 for unrecognised opcodes.
    function automatic void classify(input int op, output bit known, output int cls, output int lat);
        known = 1; cls = 0; lat = 3;
        if (op >= 'o42 && op <= 'o51)      begin cls = 0; lat = LAT_LOG; end
        else if (op >= 'o52 && op <= 'o55) begin cls = 1; lat = LAT_SH;  end
        else if (op == 'o56 || op == 'o57) begin cls = 1; lat = LAT_DSH; end
        else if (op == 'o60 || op == 'o61) begin cls = 2; lat = LAT_ADD; end
        else known = 0;
    endfunction

    function automatic bit sources_busy(input int op, input int ri, input int rj, input int rk);
        bit b = 0;
        if (op >= 'o44 && op <= 'o51)      b = (rj != 0 && m_busy[rj]) || (rk != 0 && m_busy[rk]);
        else if (op >= 'o52 && op <= 'o55) b = m_busy[ri];
        else if (op == 'o56 || op == 'o57) b = m_busy[ri] || (rj != 0 && m_busy[rj]);
        else if (op == 'o60 || op == 'o61) b = (rj != 0 && m_busy[rj]) || (rk != 0 && m_busy[rk]);
        return b;
    endfunction

    task automatic drive(input bit v, input int op, input int ri, input int rj, input int rk, output bit acc);
        rec_t r;
        bit known, ack;
        int cls, lat, slot, bm;
        @(posedge clk);
        #2;
        i_issue_vld = v;
        i_instr = 7'(op);
        i_i = 3'(ri);
        i_j = 3'(rj);
        i_k = 3'(rk);
        classify(op, known, cls, lat);
        slot = cyc % 8;
        if (known)
            ack = !sources_busy(op, ri, rj, rk) && !m_busy[ri] && !sch_v[(cyc + lat) % 8];
        else
            ack = 1;
        bm = 0;
        for (int b = 0; b < 8; b++) if (m_busy[b]) bm |= (1 << b);
        r.ack = ack;
        r.lgo = v && ack && known && cls == 0;
        r.sgo = v && ack && known && cls == 1;
        r.ago = v && ack && known && cls == 2;
        r.wbv = sch_v[slot];
        r.wbsel = sch_sel[slot];
        r.wbaddr = sch_addr[slot];
        r.busy = bm;
        r.bad = m_bad;
        exp_q.push_back(r);
        if (sch_v[slot]) m_busy[sch_addr[slot]] = 0;
        sch_v[slot] = 0;
        m_bad = 0;
        acc = v && ack;
        if (acc) begin
            if (known) begin
                m_busy[ri] = 1;
                sch_v[(cyc + lat) % 8] = 1;
                sch_sel[(cyc + lat) % 8] = cls;
                sch_addr[(cyc + lat) % 8] = ri;
            end else begin
                m_bad = 1;
            end
        end
        cyc++;
    endtask

    task automatic offer(input int op, input int ri, input int rj, input int rk);
        bit a = 0;
        int tries = 0;
        while (!a && tries < 20) begin
            drive(1, op, ri, rj, rk, a);
            tries++;
        end
        chk("offer_accepted_within_bound", int'(a), 1);
    endtask

    task automatic idle(input int cycles);
        bit a;
        for (int c = 0; c < cycles; c++) drive(0, 0, 0, 0, 0, a);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wb_vld", int'(o_wb_vld), 0);
        chk("rst_wb_sel", int'(o_wb_sel), 0);
        chk("rst_wb_addr", int'(o_wb_addr), 0);
        chk("rst_s_busy", int'(o_s_busy), 0);
        chk("rst_bad_op", int'(o_bad_op), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        i_issue_vld = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            e = exp_q.pop_front();
            chk("issue_ack", int'(o_issue_ack), int'(e.ack));
            chk("log_go", int'(o_log_go), int'(e.lgo));
            chk("sh_go", int'(o_sh_go), int'(e.sgo));
            chk("add_go", int'(o_add_go), int'(e.ago));
            chk("wb_vld", int'(o_wb_vld), int'(e.wbv));
            if (e.wbv) begin
                chk("wb_sel", int'(o_wb_sel), e.wbsel);
                chk("wb_addr", int'(o_wb_addr), e.wbaddr);
            end
            chk("s_busy", int'(o_s_busy), e.busy);
            chk("bad_op", int'(o_bad_op), int'(e.bad));
        end
    end

    initial begin
        bit a;
        int op;
        rst_n = 1'b0;
        i_issue_vld = 1'b0;
        i_instr = '0;
        i_i = '0; i_j = '0; i_k = '0;
        cyc = 0;
        model_reset();
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive(1, 'o44, 3, 1, 2, a);
        idle(3);
        drive(1, 'o60, 1, 0, 0, a);
        offer('o51, 2, 0, 0);
        idle(4);
        drive(1, 'o51, 4, 0, 0, a);
        offer('o44, 5, 4, 0);
        idle(3);
        drive(1, 'o52, 6, 0, 0, a);
        drive(1, 'o42, 7, 0, 0, a);
        offer('o52, 6, 0, 0);
        idle(4);
        drive(1, 'o61, 2, 3, 4, a);
        drive(1, 7'b0010101, 5, 5, 5, a);
        idle(3);
        drive(1, 'o60, 5, 1, 1, a);
        drive(0, 0, 0, 0, 0, a);
        apply_reset();
        idle(5);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) < 14) op = int'($urandom_range('o42, 'o61));
            else op = int'($urandom_range(0, 127));
            drive($urandom_range(0, 9) < 8, op, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), a);
            if (c == 1500) apply_reset();
        end
        idle(4);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
